// File: rtl/eth_axil_pkg.sv
// rtl/eth_axil_pkg.sv - shared types and constants for the ethernet AXI-Lite bridge
package eth_axil_pkg;

  localparam int addr_width_lp = 14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    WAIT_RESP,
    B_RESP,
    R_RESP
  } state_e;

  // Width needed to hold log2(bytes per beat) as an op_size value.
  function automatic int size_width_f(input int data_width);
    return $clog2($clog2(data_width / 8) + 1);
  endfunction

endpackage

// File: rtl/eth_axil_strb_decode.sv
// rtl/eth_axil_strb_decode.sv - maps a write strobe to {legal, op_size, byte offset}
module eth_axil_strb_decode #(
  parameter int bytes_p      = 4,
  parameter int off_width_p  = 2,
  parameter int size_width_p = 2
) (
  input  logic [bytes_p-1:0]      strb_i,
  output logic                    legal_o,
  output logic [size_width_p-1:0] size_o,
  output logic [off_width_p-1:0]  offset_o
);

  // Legal strobes are exactly the naturally aligned power-of-two runs.
  always_comb begin
    legal_o  = 1'b0;
    size_o   = '0;
    offset_o = '0;
    for (int s = 0; s <= off_width_p; s++) begin
      for (int o = 0; o < bytes_p; o += (1 << s)) begin
        if (strb_i == bytes_p'(((64'd1 << (1 << s)) - 64'd1) << o)) begin
          legal_o  = 1'b1;
          size_o   = size_width_p'(s);
          offset_o = off_width_p'(o);
        end
      end
    end
  end

endmodule

// File: rtl/ethernet_axil_bridge.sv
// rtl/ethernet_axil_bridge.sv - AXI-Lite slave issuing one controller op per read or write
module ethernet_axil_bridge
  import eth_axil_pkg::*;
#(
  parameter int axil_addr_width_p = 32,
  parameter int data_width_p      = 32,
  parameter int timeout_p         = 1024
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [axil_addr_width_p-1:0]            s_axil_awaddr_i,
  input  logic                                    s_axil_awvalid_i,
  output logic                                    s_axil_awready_o,
  input  logic [data_width_p-1:0]                 s_axil_wdata_i,
  input  logic [data_width_p/8-1:0]               s_axil_wstrb_i,
  input  logic                                    s_axil_wvalid_i,
  output logic                                    s_axil_wready_o,
  output logic [1:0]                              s_axil_bresp_o,
  output logic                                    s_axil_bvalid_o,
  input  logic                                    s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0]            s_axil_araddr_i,
  input  logic                                    s_axil_arvalid_i,
  output logic                                    s_axil_arready_o,
  output logic [data_width_p-1:0]                 s_axil_rdata_o,
  output logic [1:0]                              s_axil_rresp_o,
  output logic                                    s_axil_rvalid_o,
  input  logic                                    s_axil_rready_i,
  output logic [addr_width_lp-1:0]                addr_o,
  output logic                                    write_en_o,
  output logic                                    read_en_o,
  input  logic                                    ready_and_i,
  output logic [size_width_f(data_width_p)-1:0]   op_size_o,
  output logic [data_width_p-1:0]                 write_data_o,
  input  logic                                    valid_i,
  output logic                                    ready_and_o,
  input  logic [data_width_p-1:0]                 read_data_i
);

  localparam int bytes_lp      = data_width_p / 8;
  localparam int off_width_lp  = $clog2(bytes_lp);
  localparam int size_width_lp = size_width_f(data_width_p);
  localparam int cnt_width_lp  = $clog2(timeout_p + 1);

  logic                                 aw_full_q, w_full_q, ar_full_q;
  logic [addr_width_lp-off_width_lp-1:0] awaddr_q, araddr_q;
  logic [data_width_p-1:0]              wdata_q;
  logic [bytes_lp-1:0]                  wstrb_q;

  state_e                   state_q, state_d;
  logic                     rd_prio_q, rd_prio_d;
  logic                     op_rd_q, op_rd_d;
  logic                     owe_q, owe_d, drop_q, drop_d;
  logic [1:0]               resp_q, resp_d;
  logic [data_width_p-1:0]  rdata_q, rdata_d, wr_data_q, wr_data_d;
  logic [addr_width_lp-1:0] addr_q, addr_d;
  logic [size_width_lp-1:0] size_q, size_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;

  logic                     dec_legal;
  logic [size_width_lp-1:0] dec_size;
  logic [off_width_lp-1:0]  dec_offset;

  eth_axil_strb_decode #(
    .bytes_p      (bytes_lp),
    .off_width_p  (off_width_lp),
    .size_width_p (size_width_lp)
  ) strb_decode (
    .strb_i   (wstrb_q),
    .legal_o  (dec_legal),
    .size_o   (dec_size),
    .offset_o (dec_offset)
  );

  logic aw_take, w_take, ar_take, b_done, r_done, wr_pend, pick_wr;
  assign aw_take = s_axil_awvalid_i & ~aw_full_q;
  assign w_take  = s_axil_wvalid_i & ~w_full_q;
  assign ar_take = s_axil_arvalid_i & ~ar_full_q;
  assign b_done  = (state_q == B_RESP) & s_axil_bready_i;
  assign r_done  = (state_q == R_RESP) & s_axil_rready_i;
  assign wr_pend = aw_full_q & w_full_q;
  assign pick_wr = wr_pend & (~ar_full_q | ~rd_prio_q);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil_awaddr_i[axil_addr_width_p-1:addr_width_lp],
                              s_axil_awaddr_i[off_width_lp-1:0],
                              s_axil_araddr_i[axil_addr_width_p-1:addr_width_lp],
                              s_axil_araddr_i[off_width_lp-1:0], drop_q};

  always_comb begin
    state_d   = state_q;
    rd_prio_d = rd_prio_q;
    op_rd_d   = op_rd_q;
    owe_d     = owe_q;
    drop_d    = drop_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    size_d    = size_q;
    cnt_d     = '0;
    // A response still owed by a timed-out op is swallowed outside WAIT_RESP.
    if (owe_q && valid_i && state_q != WAIT_RESP) begin
      owe_d  = 1'b0;
      drop_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (pick_wr) begin
          rd_prio_d = 1'b1;
          op_rd_d   = 1'b0;
          addr_d    = {awaddr_q, dec_offset};
          size_d    = dec_size;
          wr_data_d = wdata_q >> {dec_offset, 3'b000};
          resp_d    = dec_legal ? RESP_OKAY : RESP_SLVERR;
          state_d   = dec_legal ? WR_ISSUE : B_RESP;
        end else if (ar_full_q) begin
          rd_prio_d = 1'b0;
          op_rd_d   = 1'b1;
          addr_d    = {araddr_q, {off_width_lp{1'b0}}};
          size_d    = size_width_lp'(off_width_lp);
          resp_d    = RESP_OKAY;
          rdata_d   = '0;
          state_d   = RD_ISSUE;
        end
      end
      WR_ISSUE, RD_ISSUE: if (ready_and_i) state_d = WAIT_RESP;
      WAIT_RESP: begin
        cnt_d = cnt_q + cnt_width_lp'(1);
        if (valid_i) begin
          if (op_rd_q) rdata_d = read_data_i;
          state_d = op_rd_q ? R_RESP : B_RESP;
        end else if (cnt_q == cnt_width_lp'(timeout_p - 1)) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          owe_d   = 1'b1;
          state_d = op_rd_q ? R_RESP : B_RESP;
        end
      end
      B_RESP: if (s_axil_bready_i) state_d = IDLE;
      R_RESP: if (s_axil_rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      state_q   <= IDLE;
      rd_prio_q <= 1'b0;
      op_rd_q   <= 1'b0;
      owe_q     <= 1'b0;
      drop_q    <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      wr_data_q <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (aw_take) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_axil_awaddr_i[addr_width_lp-1:off_width_lp];
      end else if (b_done) aw_full_q <= 1'b0;
      if (w_take) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axil_wdata_i;
        wstrb_q  <= s_axil_wstrb_i;
      end else if (b_done) w_full_q <= 1'b0;
      if (ar_take) begin
        ar_full_q <= 1'b1;
        araddr_q  <= s_axil_araddr_i[addr_width_lp-1:off_width_lp];
      end else if (r_done) ar_full_q <= 1'b0;
      state_q   <= state_d;
      rd_prio_q <= rd_prio_d;
      op_rd_q   <= op_rd_d;
      owe_q     <= owe_d;
      drop_q    <= drop_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      wr_data_q <= wr_data_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_axil_awready_o = reset_n_i & ~aw_full_q;
  assign s_axil_wready_o  = reset_n_i & ~w_full_q;
  assign s_axil_arready_o = reset_n_i & ~ar_full_q;
  assign s_axil_bvalid_o  = (state_q == B_RESP);
  assign s_axil_rvalid_o  = (state_q == R_RESP);
  assign s_axil_bresp_o   = resp_q;
  assign s_axil_rresp_o   = resp_q;
  assign s_axil_rdata_o   = rdata_q;
  assign write_en_o       = (state_q == WR_ISSUE);
  assign read_en_o        = (state_q == RD_ISSUE);
  assign addr_o           = addr_q;
  assign op_size_o        = size_q;
  assign write_data_o     = wr_data_q;
  assign ready_and_o      = reset_n_i & ((state_q == WAIT_RESP) | owe_q);

endmodule
